// File: rtl/orb_wr_if.sv
// Write-port bundle between the orbit packers / M16 bank select and the frame RAM arbiter.
// The master side drives strobes and bank select; the slave side returns the scheduled RAM write.
interface orb_wr_if #(
  parameter int unsigned NREQ = 5,
  parameter int unsigned AW   = 11,
  parameter int unsigned DW   = 12
) ();

  logic [NREQ-1:0]    iWE;
  logic [NREQ*AW-1:0] iAddr;
  logic [NREQ*DW-1:0] iData;
  logic               iSW;
  logic               iClrErr;
  logic [AW-1:0]      oWrAddr;
  logic [DW-1:0]      oWrData;
  logic               oWE1;
  logic               oWE2;
  logic               oBusy;
  logic [NREQ-1:0]    oOvf;
  logic [7:0]         oDropCnt;

  modport master (
    output iWE, iAddr, iData, iSW, iClrErr,
    input  oWrAddr, oWrData, oWE1, oWE2, oBusy, oOvf, oDropCnt
  );

  modport slave (
    input  iWE, iAddr, iData, iSW, iClrErr,
    output oWrAddr, oWrData, oWE1, oWE2, oBusy, oOvf, oDropCnt
  );

endinterface

// File: rtl/orb_wr_arbiter.sv
// Round-robin write scheduler for the ping-pong orbit frame RAM pair: per-requester FIFOs,
// one grant per clock, writes steered away from the bank M16 is reading, flush on bank switch.
module orb_wr_arbiter #(
  parameter int unsigned NREQ  = 5,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 11,
  parameter int unsigned DW    = 12
) (
  input  logic    clk,
  input  logic    rst,
  orb_wr_if.slave bus
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DCW  = 16;
  localparam int unsigned SUMW = DCW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem   [NREQ][DEPTH];
  logic [PW-1:0] rdPtr [NREQ];
  logic [PW-1:0] wrPtr [NREQ];
  logic [CW-1:0] cnt   [NREQ];
  logic          swQ;
  logic [IW-1:0] rr;

  logic [AW-1:0]   wrAddrQ;
  logic [DW-1:0]   wrDataQ;
  logic            we1Q;
  logic            we2Q;
  logic            busyQ;
  logic [NREQ-1:0] ovfQ;
  logic [7:0]      dropQ;

  logic            bankSw;
  logic            found;
  logic            grantVld;
  logic [IW-1:0]   grantIdx;
  entry_t          head;
  logic [NREQ-1:0] pop;
  logic [NREQ-1:0] accept;
  logic [NREQ-1:0] ovfSet;
  logic [CW-1:0]   cntNext [NREQ];
  logic            anyNext;
  logic [DCW-1:0]  dropAdd;
  logic [SUMW-1:0] dropSum;
  logic [7:0]      dropNext;

  assign bankSw = (bus.iSW != swQ);

  // First non-empty FIFO after the last winner; a bank switch suppresses the grant.
  always_comb begin
    found    = 1'b0;
    grantIdx = rr;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!found && (cnt[(int'(rr) + k) % int'(NREQ)] != '0)) begin
        found    = 1'b1;
        grantIdx = IW'((int'(rr) + k) % int'(NREQ));
      end
    end
    grantVld = found && !bankSw;
    head     = mem[grantIdx][rdPtr[grantIdx]];
  end

  // Push acceptance, overflow, next occupancy and the drop tally for this edge.
  always_comb begin
    pop     = '0;
    accept  = '0;
    ovfSet  = '0;
    anyNext = 1'b0;
    dropAdd = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cntNext[i] = cnt[i];
      pop[i]     = grantVld && (grantIdx == IW'(i));
      if (bankSw) begin
        accept[i]  = bus.iWE[i];
        dropAdd    = dropAdd + DCW'(cnt[i]);
        cntNext[i] = CW'(bus.iWE[i]);
      end else begin
        accept[i]  = bus.iWE[i] && ((cnt[i] != CW'(DEPTH)) || pop[i]);
        ovfSet[i]  = bus.iWE[i] && !accept[i];
        dropAdd    = dropAdd + DCW'(ovfSet[i]);
        cntNext[i] = cnt[i] - CW'(pop[i]) + CW'(accept[i]);
      end
      if (cntNext[i] != '0) anyNext = 1'b1;
    end
    dropSum  = SUMW'(bus.iClrErr ? 8'd0 : dropQ) + SUMW'(dropAdd);
    dropNext = (dropSum > SUMW'(255)) ? 8'hFF : dropSum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swQ     <= 1'b0;
      rr      <= IW'(NREQ - 1);
      wrAddrQ <= '0;
      wrDataQ <= '0;
      we1Q    <= 1'b0;
      we2Q    <= 1'b0;
      busyQ   <= 1'b0;
      ovfQ    <= '0;
      dropQ   <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        rdPtr[i] <= '0;
        wrPtr[i] <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      swQ <= bus.iSW;
      if (grantVld) begin
        rr      <= grantIdx;
        wrAddrQ <= head.addr;
        wrDataQ <= head.data;
      end
      // Grants only happen when iSW == swQ, so iSW is also the next swQ here.
      we1Q  <= grantVld && bus.iSW;
      we2Q  <= grantVld && !bus.iSW;
      busyQ <= anyNext;
      ovfQ  <= (bus.iClrErr ? '0 : ovfQ) | ovfSet;
      dropQ <= dropNext;
      for (int i = 0; i < int'(NREQ); i++) begin
        cnt[i] <= cntNext[i];
        if (bankSw)      rdPtr[i] <= wrPtr[i];
        else if (pop[i]) rdPtr[i] <= rdPtr[i] + PW'(1);
        if (accept[i])   wrPtr[i] <= wrPtr[i] + PW'(1);
      end
    end
  end

  // Entry storage carries no reset; occupancy counters decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NREQ); i++) begin
      if (accept[i]) begin
        mem[i][wrPtr[i]] <= entry_t'({bus.iAddr[i*AW +: AW], bus.iData[i*DW +: DW]});
      end
    end
  end

  assign bus.oWrAddr  = wrAddrQ;
  assign bus.oWrData  = wrDataQ;
  assign bus.oWE1     = we1Q;
  assign bus.oWE2     = we2Q;
  assign bus.oBusy    = busyQ;
  assign bus.oOvf     = ovfQ;
  assign bus.oDropCnt = dropQ;

endmodule

// File: doc/orb_wr_arbiter.md
# orb_wr_arbiter

Write-port arbiter and scheduler for the ping-pong orbit frame RAM pair.
- Accepts one-cycle write strobes (address + 12-bit orbit word) from up to five packers (fast group 1/2, slow group 1/2, temperature) and buffers each one in a small per-requester FIFO, so simultaneous strobes are not lost.
- Grants one write per clock, round-robin.
- Steers the write to the bank not currently being read by the M16 frame former.
- Flushes stale entries on every bank switch and reports overflows and drops.

## Interface

Parameters:
- NREQ, 5: number of write requesters.
- DEPTH, 2: per-requester FIFO depth; power of two, at least 2.
- AW, 11: RAM address width.
- DW, 12: orbit word width.

Ports:
- clk  in  1  system clock (80 MHz domain); one clock only.
- rst  in  1  reset, asynchronous, active-high.
- iWE  in  NREQ  write strobes, one cycle per word. Bit i belongs to requester i.
- iAddr  in  NREQ*AW  write addresses. Requester i uses [i*AW +: AW].
- iData  in  NREQ*DW  orbit words. Requester i uses [i*DW +: DW].
- iSW  in  1  bank select from M16, already synchronous to clk.
  - 0: bank 1 is being read, so writes go to bank 2.
  - 1: bank 2 is being read, so writes go to bank 1.
- iClrErr  in  1  clears oOvf and oDropCnt.
- oWrAddr  out  AW  registered write address.
- oWrData  out  DW  registered write word.
- oWE1  out  1  registered write enable, bank 1.
- oWE2  out  1  registered write enable, bank 2.
- oBusy  out  1  registered; high while any FIFO is non-empty.
- oOvf  out  NREQ  sticky per-requester overflow flags.
- oDropCnt  out  8  saturating count of discarded entries (overflow plus flush); holds at 255.

## Operation

Reset:
- All FIFOs empty.
- swQ (registered copy of iSW) = 0.
- Round-robin pointer rr = NREQ-1, so requester 0 has first priority.
- All outputs are 0.

Push:
- When iWE[i] is high at an edge, requester i's {addr, data} is written into FIFO i.
- If FIFO i is full and is not popped at that same edge, the entry is dropped, oOvf[i] is set and oDropCnt increments.
- A push into a full FIFO that is popped at the same edge is accepted.

Arbitration (evaluated every cycle):
- Search the non-empty FIFOs starting at index rr+1 mod NREQ, wrapping around.
- The first non-empty FIFO found is granted and popped at the edge; rr is set to its index.
- At most one pop per edge. If no FIFO is non-empty, there is no pop and rr holds.

Output register, at each edge:
- oWrAddr and oWrData take the granted head entry.
- With a grant: oWE2 = ~swQ_next and oWE1 = swQ_next.
- With no grant: both enables are 0.
- oWE1 and oWE2 are never high together.

Bank switch:
- A bank switch is a cycle in which iSW != swQ.
- At that edge:
  - every FIFO is emptied, discarding all entries present before the edge;
  - the number discarded is added to oDropCnt, saturating;
  - no grant is issued and oWE1 = oWE2 = 0;
  - swQ takes iSW.
- Pushes in the switch cycle are accepted into the emptied FIFOs and are written to the new bank.
- oOvf is not affected by a flush.

Error clear:
- iClrErr clears oOvf and oDropCnt at the edge.
- If an overflow occurs at the same edge, the set wins: the flag ends at 1 and the count ends at 1.

oBusy reflects the FIFO occupancy after each edge.

## Timing

- Latency from an iWE edge to the oWE edge is 1 edge when the requester's FIFO is empty and it wins arbitration. Example: iWE sampled at edge k, entry is in the FIFO after edge k, oWE is high in the cycle after edge k+1.
- Throughput: 1 write per clock in aggregate.
- Worst-case wait for an entry at the FIFO head: NREQ-1 cycles.
- FIFO pointers wrap modulo DEPTH. Each occupancy count runs 0..DEPTH.
- An asynchronous rst asserted mid-operation immediately forces:
  - all outputs to 0;
  - all FIFOs empty;
  - rr = NREQ-1.

  No partial write is emitted after rst deasserts.

## Test plan

1. **Single write.** iSW=0; iWE[2] for 1 cycle with addr 0x33F, data 0xABC.
   - Response: oWE2=1 for exactly 1 cycle, 2 edges after the strobe, with oWrAddr=0x33F and oWrData=0xABC.
   - oWE1 stays 0; oBusy pulses for 1 cycle.
2. **All requesters at once.** iWE=5'b11111 for 1 cycle, addresses 10..14.
   - Response: 5 consecutive oWE2 cycles with addresses 10, 11, 12, 13, 14 in that order.
   - oOvf=0; oDropCnt=0.
3. **Round-robin order.** Last grant was to requester 3; requesters 0 and 4 then strobe together.
   - Response: requester 4 is written first, then requester 0.
4. **Overflow.** DEPTH=2; iWE=5'b11111 on 3 consecutive cycles.
   - Response: 12 writes total, oOvf=5'b11100, oDropCnt=3.
   - The third entry of each of requesters 2, 3 and 4 is never written.
5. **Bank switch flush.**
   - Stimulus: 4 entries pending (load as in test 2, then wait one cycle); toggle iSW 0→1; in that same cycle strobe iWE[0] with addr 0x005.
   - Response: no write occurs at the switch edge and oDropCnt increases by 4.
   - Next cycle: oWE1=1 with oWrAddr=0x005; oWE2 stays 0.
6. **Reset and clear.**
   - Assert rst while 3 entries are pending: all outputs 0 at once, no writes after release.
   - Later, pulse iClrErr after test 4: oOvf=0 and oDropCnt=0.
